// File: rtl/lfsr_fifo_ctrl_pkg.sv
// lfsr_fifo_ctrl_pkg: shared state encoding and default geometry for the LFSR-to-FIFO packer
package lfsr_fifo_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FILL, PUSH, DONE} state_t;
  localparam int DEF_BITS = 1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_COUNT_WIDTH = 8;
  localparam int BITS_PER_WORD = DEF_WIDTH / DEF_BITS;
  function automatic int bits_per_word(input int w, input int b);
    return w / b;
  endfunction
endpackage

// File: rtl/lfsr_fifo_ctrl_if.sv
// lfsr_fifo_ctrl_if: request/status, LFSR and FIFO push-side signals of the controller
interface lfsr_fifo_ctrl_if #(
  parameter int LFSR_OUTPUT_BITS_PER_CLOCK = 1,
  parameter int FIFO_WIDTH = 8,
  parameter int COUNT_WIDTH = 8
);
  logic start;
  logic [COUNT_WIDTH-1:0] word_count;
  logic abort;
  logic busy;
  logic done;
  logic [COUNT_WIDTH-1:0] words_pushed;
  logic lfsr_enable;
  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] lfsr_out;
  logic lfsr_valid;
  logic fifo_push;
  logic [FIFO_WIDTH-1:0] fifo_data_in;
  logic fifo_full;
  modport master (
    output start, word_count, abort, lfsr_out, lfsr_valid, fifo_full,
    input busy, done, words_pushed, lfsr_enable, fifo_push, fifo_data_in
  );
  modport slave (
    input start, word_count, abort, lfsr_out, lfsr_valid, fifo_full,
    output busy, done, words_pushed, lfsr_enable, fifo_push, fifo_data_in
  );
endinterface

// File: rtl/lfsr_fifo_ctrl_bit_packer.sv
// bit_packer: shifts B-bit LFSR chunks into a W-bit word, oldest bits landing in the MSBs
module bit_packer
  import lfsr_fifo_ctrl_pkg::*;
#(
  parameter int B = DEF_BITS,
  parameter int W = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         shift_en,
  input  logic         clear,
  input  logic [B-1:0] bits_in,
  output logic [W-1:0] word_out,
  output logic         word_ready
);
  localparam int CNTW = $clog2(W + 1);
  logic [W-1:0] shreg_q, shreg_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign word_ready = shift_en && (cnt_q == CNTW'(W - B));
  assign word_out = shreg_q;
  always_comb begin
    shreg_d = clear ? '0 : shift_en ? (W'(shreg_q << B) | W'(bits_in)) : shreg_q;
    cnt_d = clear ? '0 : shift_en ? cnt_q + CNTW'(B) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/lfsr_fifo_ctrl.sv
// lfsr_fifo_ctrl: gates the LFSR, packs its output into FIFO words and pushes N words per request
module lfsr_fifo_ctrl
  import lfsr_fifo_ctrl_pkg::*;
#(
  parameter int LFSR_OUTPUT_BITS_PER_CLOCK = DEF_BITS,
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input logic clk,
  input logic reset_n,
  lfsr_fifo_ctrl_if.slave bus
);
  localparam int CW = COUNT_WIDTH;
  if (FIFO_WIDTH % LFSR_OUTPUT_BITS_PER_CLOCK != 0 ||
      bits_per_word(FIFO_WIDTH, LFSR_OUTPUT_BITS_PER_CLOCK) < 1) begin : g_bad_ratio
    $error("FIFO_WIDTH must be a multiple of LFSR_OUTPUT_BITS_PER_CLOCK");
  end
  state_t state_q, state_d;
  logic [CW-1:0] target_q, target_d, words_q, words_d;
  logic push, shift_en, clear, word_ready;
  assign push = state_q == PUSH && !bus.fifo_full && !bus.abort && reset_n;
  assign shift_en = state_q == FILL && bus.lfsr_valid && !bus.abort;
  assign clear = (state_q == IDLE && bus.start) || push;
  bit_packer #(.B(LFSR_OUTPUT_BITS_PER_CLOCK), .W(FIFO_WIDTH)) u_packer (
    .clk(clk),
    .reset_n(reset_n),
    .shift_en(shift_en),
    .clear(clear),
    .bits_in(bus.lfsr_out),
    .word_out(bus.fifo_data_in),
    .word_ready(word_ready)
  );
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    words_d = words_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          words_d = '0;
          target_d = bus.word_count == '0 ? target_q : bus.word_count;
          state_d = bus.word_count == '0 ? DONE : FILL;
        end
      end
      FILL: state_d = bus.abort ? IDLE : word_ready ? PUSH : FILL;
      PUSH: begin
        words_d = words_q + CW'(push);
        state_d = bus.abort ? IDLE : !push ? PUSH : (words_q + CW'(1) == target_q) ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      target_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      words_q <= words_d;
    end
  end
  assign bus.busy = state_q == FILL || state_q == PUSH;
  assign bus.done = state_q == DONE;
  assign bus.lfsr_enable = state_q == FILL;
  assign bus.fifo_push = push;
  assign bus.words_pushed = words_q;
endmodule

// File: tb/tb_lfsr_fifo_ctrl.sv
// tb_lfsr_fifo_ctrl: directed table and sequence checks of the LFSR-to-FIFO controller
module tb_lfsr_fifo_ctrl;
  localparam int B = 1;
  localparam int W = 8;
  localparam int CW = 8;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  lfsr_fifo_ctrl_if #(.LFSR_OUTPUT_BITS_PER_CLOCK(B), .FIFO_WIDTH(W), .COUNT_WIDTH(CW)) bus ();
  lfsr_fifo_ctrl #(.LFSR_OUTPUT_BITS_PER_CLOCK(B), .FIFO_WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  typedef struct {
    logic start;
    logic [7:0] wc;
    logic lo;
    logic lv;
    logic e_busy;
    logic e_done;
    logic [7:0] e_wp;
    logic e_len;
    logic e_push;
    logic e_chkd;
    logic [7:0] e_data;
  } vec_t;
  vec_t tv[12];
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.start = 0;
    bus.word_count = 0;
    bus.abort = 0;
    bus.lfsr_out = 0;
    bus.lfsr_valid = 0;
    bus.fifo_full = 0;
  endtask
  task automatic issue(input logic [7:0] wc);
    bus.start = 1;
    bus.word_count = wc;
    next();
    bus.start = 0;
    bus.word_count = 0;
  endtask
  task automatic fill(input logic [7:0] w, input string n);
    for (int i = 7; i >= 0; i--) begin
      bus.lfsr_out = w[i];
      bus.lfsr_valid = 1;
      @(negedge clk);
      chk({n, "_len"}, 32'(bus.lfsr_enable), 1);
      chk({n, "_nopush"}, 32'(bus.fifo_push), 0);
      next();
    end
    bus.lfsr_valid = 0;
  endtask
  task automatic expect_push(input logic [7:0] w, input string n);
    @(negedge clk);
    chk({n, "_push"}, 32'(bus.fifo_push), 1);
    chk({n, "_data"}, 32'(bus.fifo_data_in), 32'(w));
    chk({n, "_len_off"}, 32'(bus.lfsr_enable), 0);
    next();
  endtask
  initial begin
    logic [7:0] w3[3];
    tv[0]  = '{1, 8'd1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00};
    tv[1]  = '{0, 8'd0, 1, 1, 1, 0, 0, 1, 0, 1, 8'h00};
    tv[2]  = '{0, 8'd0, 0, 1, 1, 0, 0, 1, 0, 1, 8'h01};
    tv[3]  = '{0, 8'd0, 1, 1, 1, 0, 0, 1, 0, 1, 8'h02};
    tv[4]  = '{0, 8'd0, 1, 1, 1, 0, 0, 1, 0, 1, 8'h05};
    tv[5]  = '{0, 8'd0, 0, 1, 1, 0, 0, 1, 0, 1, 8'h0B};
    tv[6]  = '{0, 8'd0, 0, 1, 1, 0, 0, 1, 0, 1, 8'h16};
    tv[7]  = '{0, 8'd0, 1, 1, 1, 0, 0, 1, 0, 1, 8'h2C};
    tv[8]  = '{0, 8'd0, 0, 1, 1, 0, 0, 1, 0, 1, 8'h59};
    tv[9]  = '{0, 8'd0, 0, 0, 1, 0, 0, 0, 1, 1, 8'hB2};
    tv[10] = '{0, 8'd0, 0, 0, 0, 1, 1, 0, 0, 0, 8'h00};
    tv[11] = '{0, 8'd0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00};
    idle_inputs();
    next();
    next();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_wp", 32'(bus.words_pushed), 0);
    chk("rst_len", 32'(bus.lfsr_enable), 0);
    chk("rst_push", 32'(bus.fifo_push), 0);
    reset_n = 1;
    next();
    for (int i = 0; i < 12; i++) begin
      bus.start = tv[i].start;
      bus.word_count = tv[i].wc;
      bus.lfsr_out = tv[i].lo;
      bus.lfsr_valid = tv[i].lv;
      @(negedge clk);
      chk($sformatf("t%0d_busy", i), 32'(bus.busy), 32'(tv[i].e_busy));
      chk($sformatf("t%0d_done", i), 32'(bus.done), 32'(tv[i].e_done));
      chk($sformatf("t%0d_wp", i), 32'(bus.words_pushed), 32'(tv[i].e_wp));
      chk($sformatf("t%0d_len", i), 32'(bus.lfsr_enable), 32'(tv[i].e_len));
      chk($sformatf("t%0d_push", i), 32'(bus.fifo_push), 32'(tv[i].e_push));
      if (tv[i].e_chkd) chk($sformatf("t%0d_data", i), 32'(bus.fifo_data_in), 32'(tv[i].e_data));
      next();
    end
    idle_inputs();
    for (int j = 0; j < 3; j++) w3[j] = 8'($urandom);
    issue(8'd3);
    for (int j = 0; j < 3; j++) begin
      fill(w3[j], $sformatf("three_w%0d", j));
      expect_push(w3[j], $sformatf("three_w%0d", j));
    end
    @(negedge clk);
    chk("three_done", 32'(bus.done), 1);
    chk("three_busy_done", 32'(bus.busy), 0);
    next();
    @(negedge clk);
    chk("three_wp", 32'(bus.words_pushed), 3);
    chk("three_busy_after", 32'(bus.busy), 0);
    chk("three_done_clr", 32'(bus.done), 0);
    issue(8'd2);
    fill(8'hA7, "stall_w0");
    bus.fifo_full = 1;
    for (int k = 0; k < 5; k++) begin
      bus.lfsr_valid = 1;
      bus.lfsr_out = 1'(k);
      @(negedge clk);
      chk("stall_nopush", 32'(bus.fifo_push), 0);
      chk("stall_data", 32'(bus.fifo_data_in), 32'h A7);
      chk("stall_len", 32'(bus.lfsr_enable), 0);
      chk("stall_busy", 32'(bus.busy), 1);
      next();
    end
    bus.fifo_full = 0;
    bus.lfsr_valid = 0;
    expect_push(8'hA7, "stall_w0");
    fill(8'h3C, "stall_w1");
    expect_push(8'h3C, "stall_w1");
    @(negedge clk);
    chk("stall_done", 32'(bus.done), 1);
    chk("stall_wp", 32'(bus.words_pushed), 2);
    next();
    issue(8'd1);
    for (int k = 0; k < 4; k++) begin
      bus.lfsr_valid = 1;
      bus.lfsr_out = 1;
      next();
    end
    bus.abort = 1;
    bus.lfsr_out = 1;
    next();
    bus.abort = 0;
    bus.lfsr_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_push", 32'(bus.fifo_push), 0);
      chk("abort_done", 32'(bus.done), 0);
      chk("abort_wp", 32'(bus.words_pushed), 0);
      next();
    end
    issue(8'd1);
    fill(8'h4D, "abort_new");
    expect_push(8'h4D, "abort_new");
    @(negedge clk);
    chk("abort_new_done", 32'(bus.done), 1);
    next();
    bus.start = 1;
    bus.word_count = 0;
    @(negedge clk);
    chk("zero_len_idle", 32'(bus.lfsr_enable), 0);
    next();
    bus.start = 0;
    @(negedge clk);
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_busy", 32'(bus.busy), 0);
    chk("zero_len", 32'(bus.lfsr_enable), 0);
    chk("zero_push", 32'(bus.fifo_push), 0);
    chk("zero_wp", 32'(bus.words_pushed), 0);
    next();
    @(negedge clk);
    chk("zero_done_clr", 32'(bus.done), 0);
    issue(8'd1);
    fill(8'hE1, "ign");
    bus.start = 1;
    bus.word_count = 8'd5;
    expect_push(8'hE1, "ign");
    bus.start = 0;
    bus.word_count = 0;
    @(negedge clk);
    chk("ign_done", 32'(bus.done), 1);
    chk("ign_wp", 32'(bus.words_pushed), 1);
    next();
    @(negedge clk);
    chk("ign_idle", 32'(bus.busy), 0);
    issue(8'd2);
    fill(8'h96, "rst");
    reset_n = 0;
    @(negedge clk);
    chk("rst_mid_push", 32'(bus.fifo_push), 0);
    next();
    reset_n = 1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    chk("rst_mid_wp", 32'(bus.words_pushed), 0);
    chk("rst_mid_len", 32'(bus.lfsr_enable), 0);
    chk("rst_mid_data", 32'(bus.fifo_data_in), 0);
    for (int k = 0; k < 3; k++) begin
      bus.lfsr_valid = 1;
      bus.lfsr_out = 1;
      next();
    end
    bus.lfsr_valid = 0;
    issue(8'd1);
    fill(8'h3C, "post_rst");
    expect_push(8'h3C, "post_rst");
    @(negedge clk);
    chk("post_rst_done", 32'(bus.done), 1);
    next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_fifo_ctrl.md
Name: lfsr_fifo_ctrl

Overview:
Sequences the Galois LFSR → FIFO datapath so that bulk random words can be requested on demand.
On a start request for N words, it gates the LFSR enable and packs LFSR_OUTPUT_BITS_PER_CLOCK-bit LFSR outputs into full FIFO_WIDTH-bit words, with no zero-padding.
It pushes each word into the FIFO, respecting backpressure from full. It reports busy, words delivered and a done pulse.
It sits between the LFSR instance and the FIFO push side, replacing the direct valid→push wiring.

Parameters:
LFSR_OUTPUT_BITS_PER_CLOCK, 1, LFSR bits per valid cycle (B). FIFO_WIDTH must be an integer multiple of B; elaboration-time error otherwise.
FIFO_WIDTH, 8, FIFO word width (W).
COUNT_WIDTH, 8, width of the word-count request and progress counter.

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
word_count  input  COUNT_WIDTH  number of words to produce; sampled with start
abort  input  1  cancel the current request
busy  output  1  high in FILL or PUSH
done  output  1  one-cycle pulse on request completion
words_pushed  output  COUNT_WIDTH  words pushed for the current/last request
lfsr_enable  output  1  to LFSR enable
lfsr_out  input  B  LFSR output bits
lfsr_valid  input  1  LFSR output valid
fifo_push  output  1  to FIFO push
fifo_data_in  output  W  to FIFO data_in
fifo_full  input  1  from FIFO full

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE; busy=0, done=0, lfsr_enable=0, words_pushed=0, shift register=0, bit counter=0, target=0.
  - fifo_push is forced 0 in any cycle where reset_n=0.
  - Reset mid-operation abandons the request: no push, no done.
- States: IDLE, FILL, PUSH, DONE. All registers update on posedge clk.
- IDLE:
  - lfsr_enable=0, busy=0.
  - start=1 and word_count!=0: latch target=word_count, clear words_pushed, shift register and bit counter; next state FILL.
  - start=1 and word_count==0: clear words_pushed; next state DONE, so done pulses the following cycle.
- FILL:
  - lfsr_enable=1 (registered, asserted from the first FILL cycle).
  - Each cycle with lfsr_valid=1: shreg <= {shreg[W-B-1:0], lfsr_out}, so the oldest bit ends up in the MSB; bit_cnt += B.
  - When the valid cycle brings bit_cnt to W, go to PUSH; that cycle's bits are included in the word.
  - lfsr_valid=0 cycles: hold.
- PUSH:
  - lfsr_enable=0; fifo_data_in = shreg (held stable).
  - fifo_push = (state==PUSH) && !fifo_full && !abort && reset_n (combinational).
  - On push: words_pushed++, bit_cnt=0. If words_pushed+1==target go to DONE, else go to FILL.
  - fifo_full=1: stall in PUSH indefinitely; data held; no LFSR bits consumed.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
- lfsr_valid outside FILL (e.g. LFSR pipeline latency after enable drops): bits discarded, never packed.
- abort=1 in FILL or PUSH:
  - Next state IDLE; no push in that cycle (abort beats push).
  - Partial word discarded; done not asserted.
  - words_pushed keeps the count achieved so far.
- abort in IDLE or DONE: ignored.
- start while busy or in DONE: ignored.
- words_pushed holds its final value after done until the next accepted start.
- Latency (B=1, W=8, lfsr_valid every FILL cycle):
  - start sampled at edge 0, FILL occupies cycles 1–8, first push in cycle 9.
  - Steady throughput is one word per W/B+1 cycles.
- Counter wrap: target is at most 2^COUNT_WIDTH−1, so words_pushed never wraps within a request.

Decomposition:
- Package lfsr_fifo_ctrl_pkg: state enum typedef (IDLE, FILL, PUSH, DONE), plus the localparam BITS_PER_WORD = W/B.
- One sub-module, bit_packer: shift register + bit counter. Ports: shift_en, clear, bits_in, word_out, word_ready.
- The FSM, counters and push gating stay in lfsr_fifo_ctrl.

Test Plan:
- B=1, W=8, start with word_count=1, lfsr_valid=1 every FILL cycle, lfsr_out sequence 1,0,1,1,0,0,1,0 → fifo_push=1 in cycle 9 with fifo_data_in=0xB2; done in cycle 10; words_pushed=1; lfsr_enable=1 only in cycles 1–8.
- word_count=3, fifo_full=0 → 3 pushes spaced 9 cycles apart; done one cycle after the third push; words_pushed=3; busy=0 afterwards.
- word_count=2, fifo_full=1 for 5 cycles on entering the first PUSH → push delayed exactly 5 cycles; fifo_data_in unchanged throughout; lfsr_enable=0 during the stall.
- abort after 4 bits packed in FILL → IDLE next cycle; no push, no done, words_pushed=0. A new start then produces a word built from 8 fresh bits.
- start with word_count=0 → done pulse the next cycle; lfsr_enable and fifo_push never asserted. A start issued while busy is ignored (target unchanged).
- reset_n=0 on a PUSH cycle with fifo_full=0 → fifo_push=0 that cycle; all outputs at reset values next cycle. lfsr_valid pulses arriving in IDLE do not alter the next word.
